driver_sequencer: RTL and testbench
===================================

Name: driver_sequencer

Overview:
Controller that sequences one driver program. It pops matched address/vector pairs from the address FIFO and the vector FIFO in lockstep and presents them to the pin driver through a valid/ready output stage. It generates the active_program, end_program and run_program framing consumed by driver_monitor. It also enforces the program length and applies a starvation timeout.

Parameters:
ADDR_W, 16, address FIFO word width
VCTR_W, 64, vector FIFO word width
CNT_W, 16, width of length and statistics counters
STALL_LIMIT, 1024, consecutive starved cycles in RUN before the program is aborted with error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run_program  in  1  start pulse; sampled only in IDLE
abort_program  in  1  software abort; level, sampled every cycle
program_len  in  CNT_W  number of vectors to issue; latched on start
addr_fifo_empty  in  1  address FIFO empty (first-word-fall-through)
addr_fifo_dout  in  ADDR_W  address FIFO head word
addr_fifo_rd  out  1  address FIFO pop
vctr_fifo_empty  in  1  vector FIFO empty (first-word-fall-through)
vctr_fifo_dout  in  VCTR_W  vector FIFO head word
vctr_fifo_rd  out  1  vector FIFO pop
drv_valid  out  1  output pair valid
drv_ready  in  1  driver accepts pair
drv_addr  out  ADDR_W  registered address
drv_vector  out  VCTR_W  registered vector
active_program  out  1  high from the cycle after start until end_program
end_program  out  1  one-cycle pulse when the program terminates
prog_error  out  1  sticky; set by timeout; cleared on next accepted start
vec_issued  out  CNT_W  drv_valid&&drv_ready handshakes this program; saturating
stall_cycles  out  CNT_W  total starved cycles this program; saturating

Behaviour:
- Reset (synchronous, active-high):
  - State is IDLE.
  - All outputs are 0, including drv_addr and drv_vector.
  - Internal read counter and consecutive-stall counter are 0.
  - Reset asserted mid-program abandons the program with no end_program pulse.
- States: IDLE, RUN, DRAIN, DONE (encoded in the package).
- IDLE:
  - run_program=1, abort_program=0, program_len!=0: latch program_len; clear vec_issued, stall_cycles and prog_error; go to RUN.
  - Same with program_len==0: go directly to DONE; no FIFO access.
  - run_program together with abort_program: ignored; stay in IDLE.
- active_program:
  - Registered; equals 1 exactly while in RUN or DRAIN.
  - run_program received while not in IDLE is ignored.
- RUN:
  - can_pop = !addr_fifo_empty && !vctr_fifo_empty && (rd_cnt < len) && (!drv_valid || drv_ready).
  - addr_fifo_rd = vctr_fifo_rd = can_pop. Both FIFOs always pop in the same cycle; a single FIFO never pops alone.
  - On pop: drv_addr and drv_vector load the FIFO heads, drv_valid=1 on the next cycle (one-cycle latency), rd_cnt increments.
  - Starved cycle: rd_cnt < len, the output stage is free, and either FIFO is empty.
    - stall_cycles increments, saturating at all-ones.
    - The consecutive-stall counter increments; it clears on any pop.
  - Backpressure (drv_valid && !drv_ready) is not a starved cycle.
  - Consecutive-stall counter reaching STALL_LIMIT: set prog_error, clear drv_valid, go to DONE.
  - rd_cnt == len after a pop: go to DRAIN.
- DRAIN:
  - No pops.
  - Go to DONE in the cycle after the final handshake, i.e. once drv_valid has dropped.
- Output stage:
  - drv_valid clears on a handshake unless a pop loads a new pair in the same cycle.
  - Full throughput: one pair per cycle while drv_ready=1 and neither FIFO is empty.
  - drv_addr and drv_vector are stable while drv_valid && !drv_ready.
- abort_program=1 in RUN or DRAIN:
  - drv_valid is forced to 0 on the next cycle; no pops that cycle; go to DONE.
  - prog_error is unchanged.
  - FIFO contents are left for software to flush.
- DONE:
  - end_program=1 for exactly one cycle; active_program=0; return to IDLE.
- Counters: vec_issued and stall_cycles hold their values in IDLE until the next accepted start.

Decomposition:
- Package driver_pkg holds:
  - the seq_state_t enum {IDLE, RUN, DRAIN, DONE};
  - default widths DRV_ADDR_W=16, DRV_VCTR_W=64, DRV_CNT_W=16;
  - DRV_STALL_LIMIT=1024.
- One natural sub-module, driver_out_stage: one-entry valid/ready register with a load/flush interface. The state machine and counters remain in driver_sequencer.

Test Plan:
- Preload 4 pairs (addr 0x10..0x13), program_len=4, drv_ready=1, pulse run_program -> drv_valid high 4 consecutive cycles with addr 0x10..0x13; end_program pulses exactly once; vec_issued=4; stall_cycles=0; prog_error=0.
- Same stimulus with drv_ready toggling 1,0,0,1,... -> drv_addr/drv_vector stable while stalled; no FIFO pop while drv_valid&&!drv_ready; vec_issued=4; stall_cycles=0.
- Vector FIFO empty for 7 cycles mid-program while address FIFO non-empty -> no pops during the gap; stall_cycles=7; pairs stay matched (addr N always with vector N).
- program_len=3, only 2 pairs ever written, STALL_LIMIT=16 -> exactly 16 starved cycles after pair 2; prog_error=1; end_program pulse; vec_issued=2; next run_program clears prog_error.
- abort_program asserted in cycle 2 of a 10-vector program -> drv_valid 0 next cycle; end_program next cycle; active_program falls; no further pops; run_program with program_len=0 -> end_program one cycle later, no pops.
- reset asserted mid-RUN with drv_valid=1 -> next cycle all outputs 0, state IDLE, no end_program pulse.

Source files
------------

// File: rtl/driver_pkg.sv
// Shared types and default sizing for the driver program sequencer.
package driver_pkg;

    localparam int unsigned DRV_ADDR_W      = 16;
    localparam int unsigned DRV_VCTR_W      = 64;
    localparam int unsigned DRV_CNT_W       = 16;
    localparam int unsigned DRV_STALL_LIMIT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/driver_out_stage.sv
// One-entry valid/ready holding register between the FIFOs and the pin driver.
module driver_out_stage #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned VCTR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              ready_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [VCTR_W-1:0] vctr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [VCTR_W-1:0] vctr_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [VCTR_W-1:0] vctr_q;

    // Flush wins over load; payload only changes on load so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            vctr_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            vctr_q  <= vctr_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign vctr_o  = vctr_q;

endmodule

// File: rtl/driver_sequencer.sv
// Sequences one driver program: lockstep address/vector pops, length limit,
// starvation timeout and program framing for the monitor.
module driver_sequencer
    import driver_pkg::*;
#(
    parameter int unsigned ADDR_W      = DRV_ADDR_W,
    parameter int unsigned VCTR_W      = DRV_VCTR_W,
    parameter int unsigned CNT_W       = DRV_CNT_W,
    parameter int unsigned STALL_LIMIT = DRV_STALL_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_program,
    input  logic              abort_program,
    input  logic [CNT_W-1:0]  program_len,
    input  logic              addr_fifo_empty,
    input  logic [ADDR_W-1:0] addr_fifo_dout,
    output logic              addr_fifo_rd,
    input  logic              vctr_fifo_empty,
    input  logic [VCTR_W-1:0] vctr_fifo_dout,
    output logic              vctr_fifo_rd,
    output logic              drv_valid,
    input  logic              drv_ready,
    output logic [ADDR_W-1:0] drv_addr,
    output logic [VCTR_W-1:0] drv_vector,
    output logic              active_program,
    output logic              end_program,
    output logic              prog_error,
    output logic [CNT_W-1:0]  vec_issued,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]   vec_issued_q, vec_issued_d;
    logic               err_q, err_d;
    logic               active_q, end_q;

    logic hs, out_free, fifo_ok, pending, can_pop, starved, pop, flush;

    assign hs       = drv_valid && drv_ready;
    assign out_free = !drv_valid || drv_ready;
    assign fifo_ok  = !addr_fifo_empty && !vctr_fifo_empty;
    assign pending  = rd_cnt_q < len_q;
    assign can_pop  = pending && out_free && fifo_ok;
    assign starved  = pending && out_free && !fifo_ok;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        rd_cnt_d       = rd_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        stall_cycles_d = stall_cycles_q;
        err_d          = err_q;
        vec_issued_d   = (hs && (vec_issued_q != '1)) ? vec_issued_q + CNT_W'(1) : vec_issued_q;
        pop            = 1'b0;
        flush          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run_program && !abort_program) begin
                    len_d          = program_len;
                    rd_cnt_d       = '0;
                    stall_cnt_d    = '0;
                    stall_cycles_d = '0;
                    vec_issued_d   = '0;
                    err_d          = 1'b0;
                    state_d        = (program_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_program) begin
                    flush   = 1'b1;
                    state_d = DONE;
                end else if (can_pop) begin
                    pop         = 1'b1;
                    rd_cnt_d    = rd_cnt_q + CNT_W'(1);
                    stall_cnt_d = '0;
                    if (rd_cnt_d == len_q) state_d = DRAIN;
                end else if (starved) begin
                    if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                    if (stall_cnt_d == STALL_W'(STALL_LIMIT)) begin
                        err_d   = 1'b1;
                        flush   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DRAIN: begin
                if (abort_program) begin
                    flush   = 1'b1;
                    state_d = DONE;
                end else if (out_free) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            rd_cnt_q       <= '0;
            stall_cnt_q    <= '0;
            stall_cycles_q <= '0;
            vec_issued_q   <= '0;
            err_q          <= 1'b0;
            active_q       <= 1'b0;
            end_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            rd_cnt_q       <= rd_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            vec_issued_q   <= vec_issued_d;
            err_q          <= err_d;
            active_q       <= (state_d == RUN) || (state_d == DRAIN);
            end_q          <= (state_d == DONE);
        end
    end

    // Pops are suppressed while reset is asserted so an abandoned program drops no words.
    assign addr_fifo_rd   = pop && !reset;
    assign vctr_fifo_rd   = pop && !reset;
    assign active_program = active_q;
    assign end_program    = end_q;
    assign prog_error     = err_q;
    assign vec_issued     = vec_issued_q;
    assign stall_cycles   = stall_cycles_q;

    driver_out_stage #(
        .ADDR_W (ADDR_W),
        .VCTR_W (VCTR_W)
    ) u_out_stage (
        .clk     (clk),
        .reset   (reset),
        .load_i  (pop),
        .flush_i (flush),
        .ready_i (drv_ready),
        .addr_i  (addr_fifo_dout),
        .vctr_i  (vctr_fifo_dout),
        .valid_o (drv_valid),
        .addr_o  (drv_addr),
        .vctr_o  (drv_vector)
    );

endmodule

// File: tb/tb_driver_sequencer.sv
// Self-checking bench for driver_sequencer: queue-based FIFO/scoreboard model
// with directed scenarios and randomized programs.
module tb_driver_sequencer;

    localparam int unsigned AW    = 16;
    localparam int unsigned VW    = 64;
    localparam int unsigned CW    = 16;
    localparam int unsigned LIMIT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, run_program, abort_program;
    logic [CW-1:0] program_len;
    logic          addr_fifo_empty, vctr_fifo_empty, addr_fifo_rd, vctr_fifo_rd;
    logic [AW-1:0] addr_fifo_dout, drv_addr;
    logic [VW-1:0] vctr_fifo_dout, drv_vector;
    logic          drv_valid, drv_ready, active_program, end_program, prog_error;
    logic [CW-1:0] vec_issued, stall_cycles;

    driver_sequencer #(
        .ADDR_W(AW), .VCTR_W(VW), .CNT_W(CW), .STALL_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .run_program(run_program), .abort_program(abort_program),
        .program_len(program_len),
        .addr_fifo_empty(addr_fifo_empty), .addr_fifo_dout(addr_fifo_dout), .addr_fifo_rd(addr_fifo_rd),
        .vctr_fifo_empty(vctr_fifo_empty), .vctr_fifo_dout(vctr_fifo_dout), .vctr_fifo_rd(vctr_fifo_rd),
        .drv_valid(drv_valid), .drv_ready(drv_ready), .drv_addr(drv_addr), .drv_vector(drv_vector),
        .active_program(active_program), .end_program(end_program), .prog_error(prog_error),
        .vec_issued(vec_issued), .stall_cycles(stall_cycles)
    );

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] aq[$];
    logic [VW-1:0] vq[$];
    logic [AW-1:0] ea[$];
    logic [VW-1:0] ev[$];

    int cyc = 0;
    int ready_mode = 0;
    int gap_left = 0;
    int end_cnt, hs_cnt, pop_cnt, hs_first, hs_last;

    task automatic push_pair(input logic [AW-1:0] a);
        logic [VW-1:0] v;
        v = {$urandom, $urandom};
        aq.push_back(a);
        vq.push_back(v);
        ea.push_back(a);
        ev.push_back(v);
    endtask

    task automatic new_test();
        aq.delete(); vq.delete(); ea.delete(); ev.delete();
        end_cnt = 0; hs_cnt = 0; pop_cnt = 0; hs_first = 0; hs_last = 0;
        gap_left = 0;
    endtask

    // One clock: check the decisions for the coming edge, advance, model the FIFOs, redrive.
    task automatic step();
        logic          pop, stalled;
        logic [AW-1:0] a_pre, ea_h;
        logic [VW-1:0] v_pre, ev_h;
        total++;
        if (addr_fifo_rd !== vctr_fifo_rd) begin
            bad++;
            $display("FAIL pop_match cyc=%0d addr_rd=%b vctr_rd=%b", cyc, addr_fifo_rd, vctr_fifo_rd);
        end
        pop = (addr_fifo_rd === 1'b1);
        if (pop) begin
            total++;
            if (addr_fifo_empty || vctr_fifo_empty || (drv_valid && !drv_ready)) begin
                bad++;
                $display("FAIL pop_legal cyc=%0d a_empty=%b v_empty=%b valid=%b ready=%b required no pop",
                         cyc, addr_fifo_empty, vctr_fifo_empty, drv_valid, drv_ready);
            end
        end
        if (drv_valid === 1'b1 && drv_ready && !reset) begin
            hs_cnt++;
            if (hs_cnt == 1) hs_first = cyc;
            hs_last = cyc;
            total++;
            if (ea.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow cyc=%0d addr=%h required no handshake", cyc, drv_addr);
            end else begin
                ea_h = ea.pop_front();
                ev_h = ev.pop_front();
                if (drv_addr !== ea_h || drv_vector !== ev_h) begin
                    bad++;
                    $display("FAIL pair cyc=%0d got=%h/%h required=%h/%h", cyc, drv_addr, drv_vector, ea_h, ev_h);
                end
            end
        end
        stalled = (drv_valid === 1'b1) && (drv_ready === 1'b0) && !reset && !abort_program;
        a_pre = drv_addr;
        v_pre = drv_vector;
        @(posedge clk);
        @(negedge clk);
        if (pop && aq.size() != 0 && vq.size() != 0) begin
            pop_cnt++;
            void'(aq.pop_front());
            void'(vq.pop_front());
        end
        cyc++;
        case (ready_mode)
            0:       drv_ready = 1'b1;
            1:       drv_ready = (cyc % 3 == 0);
            default: drv_ready = 1'($urandom_range(0, 1));
        endcase
        addr_fifo_empty = (aq.size() == 0);
        addr_fifo_dout  = (aq.size() != 0) ? aq[0] : '0;
        vctr_fifo_empty = (vq.size() == 0) || (gap_left > 0);
        vctr_fifo_dout  = (vq.size() != 0) ? vq[0] : '0;
        if (gap_left > 0) gap_left--;
        #1;
        if (end_program === 1'b1) end_cnt++;
        if (stalled) begin
            total++;
            if (drv_valid !== 1'b1 || drv_addr !== a_pre || drv_vector !== v_pre) begin
                bad++;
                $display("FAIL hold cyc=%0d got=%b %h/%h required=1 %h/%h",
                         cyc, drv_valid, drv_addr, drv_vector, a_pre, v_pre);
            end
        end
    endtask

    task automatic start_prog(input int len);
        program_len = CW'(len);
        run_program = 1'b1;
        step();
        run_program = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        int e0 = end_cnt;
        while (end_cnt == e0 && n < budget) begin
            step();
            n++;
        end
        total++;
        if (end_cnt == e0) begin
            bad++;
            $display("FAIL end_timeout waited=%0d cycles required end_program", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++;
        if ({drv_valid, active_program, end_program, prog_error, addr_fifo_rd, vctr_fifo_rd} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b required=000000",
                     {drv_valid, active_program, end_program, prog_error, addr_fifo_rd, vctr_fifo_rd});
        end
        total++;
        if (drv_addr !== '0 || drv_vector !== '0 || vec_issued !== '0 || stall_cycles !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%0d/%0d required=0", drv_addr, drv_vector, vec_issued, stall_cycles);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        new_test();
        ready_mode = 0;
        for (int i = 0; i < 4; i++) push_pair(AW'(16 + i));
        step();
        start_prog(4);
        total++;
        if (active_program !== 1'b1 || drv_valid !== 1'b0 || addr_fifo_rd !== 1'b1) begin
            bad++;
            $display("FAIL basic_first got act=%b valid=%b rd=%b required 1 0 1", active_program, drv_valid, addr_fifo_rd);
        end
        wait_end(30);
        repeat (3) step();
        total++;
        if (hs_cnt != 4 || hs_last - hs_first != 3) begin
            bad++;
            $display("FAIL basic_burst got hs=%0d span=%0d required 4 3", hs_cnt, hs_last - hs_first);
        end
        total++;
        if (vec_issued !== 16'd4 || stall_cycles !== 16'd0 || prog_error !== 1'b0 || end_cnt != 1 || active_program !== 1'b0) begin
            bad++;
            $display("FAIL basic_final got vec=%0d stall=%0d err=%b ends=%0d act=%b required 4 0 0 1 0",
                     vec_issued, stall_cycles, prog_error, end_cnt, active_program);
        end
    endtask

    task automatic test_backpressure();
        new_test();
        ready_mode = 1;
        for (int i = 0; i < 4; i++) push_pair(AW'(16 + i));
        step();
        start_prog(4);
        wait_end(60);
        repeat (2) step();
        total++;
        if (vec_issued !== 16'd4 || stall_cycles !== 16'd0 || hs_cnt != 4 || end_cnt != 1) begin
            bad++;
            $display("FAIL bp_final got vec=%0d stall=%0d hs=%0d ends=%0d required 4 0 4 1",
                     vec_issued, stall_cycles, hs_cnt, end_cnt);
        end
    endtask

    task automatic test_vgap();
        new_test();
        ready_mode = 0;
        for (int i = 0; i < 8; i++) push_pair(AW'(32 + i));
        step();
        start_prog(8);
        step();
        step();
        gap_left = 7;
        wait_end(60);
        repeat (2) step();
        total++;
        if (stall_cycles !== 16'd7 || vec_issued !== 16'd8 || hs_cnt != 8 || prog_error !== 1'b0) begin
            bad++;
            $display("FAIL vgap got stall=%0d vec=%0d hs=%0d err=%b required 7 8 8 0",
                     stall_cycles, vec_issued, hs_cnt, prog_error);
        end
    endtask

    task automatic test_timeout();
        new_test();
        ready_mode = 0;
        push_pair(16'h0040);
        push_pair(16'h0041);
        step();
        start_prog(3);
        wait_end(LIMIT + 30);
        repeat (2) step();
        total++;
        if (prog_error !== 1'b1 || vec_issued !== 16'd2 || stall_cycles !== CW'(LIMIT) || end_cnt != 1) begin
            bad++;
            $display("FAIL timeout got err=%b vec=%0d stall=%0d ends=%0d required 1 2 %0d 1",
                     prog_error, vec_issued, stall_cycles, end_cnt, LIMIT);
        end
        new_test();
        push_pair(16'h0050);
        push_pair(16'h0051);
        step();
        start_prog(2);
        total++;
        if (prog_error !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got=%b required=0", prog_error);
        end
        wait_end(30);
        total++;
        if (vec_issued !== 16'd2 || stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL rerun got vec=%0d stall=%0d required 2 0", vec_issued, stall_cycles);
        end
    endtask

    task automatic test_abort();
        int pops;
        new_test();
        ready_mode = 0;
        for (int i = 0; i < 10; i++) push_pair(AW'(96 + i));
        step();
        start_prog(10);
        step();
        abort_program = 1'b1;
        #1;
        total++;
        if (addr_fifo_rd !== 1'b0) begin
            bad++;
            $display("FAIL abort_nopop got rd=%b required=0", addr_fifo_rd);
        end
        step();
        abort_program = 1'b0;
        total++;
        if (drv_valid !== 1'b0 || end_program !== 1'b1 || active_program !== 1'b0) begin
            bad++;
            $display("FAIL abort_next got valid=%b end=%b act=%b required 0 1 0", drv_valid, end_program, active_program);
        end
        pops = pop_cnt;
        repeat (4) step();
        total++;
        if (pop_cnt != pops || end_cnt != 1 || aq.size() != 10 - pop_cnt) begin
            bad++;
            $display("FAIL abort_after got pops=%0d/%0d ends=%0d left=%0d required same,1,%0d",
                     pop_cnt, pops, end_cnt, aq.size(), 10 - pop_cnt);
        end
        // Start with abort held is ignored; zero-length start ends at once without popping.
        new_test();
        for (int i = 0; i < 3; i++) push_pair(AW'(200 + i));
        step();
        abort_program = 1'b1;
        start_prog(5);
        abort_program = 1'b0;
        step();
        step();
        total++;
        if (active_program !== 1'b0 || end_cnt != 0 || pop_cnt != 0) begin
            bad++;
            $display("FAIL start_abort got act=%b ends=%0d pops=%0d required 0 0 0", active_program, end_cnt, pop_cnt);
        end
        start_prog(0);
        total++;
        if (end_program !== 1'b1 || active_program !== 1'b0) begin
            bad++;
            $display("FAIL zero_len got end=%b act=%b required 1 0", end_program, active_program);
        end
        repeat (3) step();
        total++;
        if (pop_cnt != 0 || end_cnt != 1 || vec_issued !== 16'd0) begin
            bad++;
            $display("FAIL zero_len_after got pops=%0d ends=%0d vec=%0d required 0 1 0", pop_cnt, end_cnt, vec_issued);
        end
    endtask

    task automatic test_reset_mid();
        new_test();
        ready_mode = 0;
        for (int i = 0; i < 6; i++) push_pair(AW'(300 + i));
        step();
        start_prog(6);
        step();
        step();
        total++;
        if (drv_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_valid got=%b required=1", drv_valid);
        end
        reset = 1'b1;
        step();
        total++;
        if ({drv_valid, active_program, end_program, prog_error} !== 4'b0 || drv_addr !== '0 ||
            drv_vector !== '0 || vec_issued !== '0 || stall_cycles !== '0) begin
            bad++;
            $display("FAIL mid_reset got %b %h/%h %0d %0d required all 0",
                     {drv_valid, active_program, end_program, prog_error}, drv_addr, drv_vector, vec_issued, stall_cycles);
        end
        reset = 1'b0;
        repeat (3) step();
        total++;
        if (end_cnt != 0 || active_program !== 1'b0) begin
            bad++;
            $display("FAIL mid_after got ends=%0d act=%b required 0 0", end_cnt, active_program);
        end
    endtask

    task automatic test_random();
        int len;
        for (int k = 0; k < 4; k++) begin
            new_test();
            ready_mode = 2;
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len + 2; i++) push_pair(AW'($urandom));
            step();
            start_prog(len);
            wait_end(200);
            repeat (2) step();
            total++;
            if (vec_issued !== CW'(len) || hs_cnt != len || stall_cycles !== 16'd0 ||
                aq.size() != 2 || end_cnt != 1 || prog_error !== 1'b0) begin
                bad++;
                $display("FAIL random%0d got vec=%0d hs=%0d stall=%0d left=%0d ends=%0d err=%b required %0d %0d 0 2 1 0",
                         k, vec_issued, hs_cnt, stall_cycles, aq.size(), end_cnt, prog_error, len, len);
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        run_program     = 1'b0;
        abort_program   = 1'b0;
        program_len     = '0;
        addr_fifo_empty = 1'b1;
        vctr_fifo_empty = 1'b1;
        addr_fifo_dout  = '0;
        vctr_fifo_dout  = '0;
        drv_ready       = 1'b1;
        new_test();
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_vgap();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
